// File: rtl/cond_unit_if.sv
// cond_unit_if: branch resolution handshake between a branch source and
// the condition unit.
//
// Handshake: a branch is presented with br_valid=1 together with br_kind,
// br_cond and reg_zero. It is accepted in any cycle where br_valid and
// br_ready are both 1. While br_valid=1 and br_ready=0 the source holds
// br_kind, br_cond and reg_zero stable. One cycle after acceptance the unit
// pulses res_valid for one cycle. res_taken carries the decision and is
// meaningful only while res_valid=1.
//
// Signals:
//   br_valid   source -> unit  branch presented
//   br_ready   unit -> source  unit can accept the branch this cycle
//   br_kind    source -> unit  00 B.cond, 01 CBZ, 10 CBNZ, 11 B
//   br_cond    source -> unit  ARM condition field (B.cond only)
//   reg_zero   source -> unit  tested register == 0 (CBZ/CBNZ only)
//   res_valid  unit -> source  one-cycle resolution pulse
//   res_taken  unit -> source  branch taken decision
interface cond_unit_if;
    logic       br_valid;
    logic       br_ready;
    logic [1:0] br_kind;
    logic [3:0] br_cond;
    logic       reg_zero;
    logic       res_valid;
    logic       res_taken;

    modport master (
        output br_valid, br_kind, br_cond, reg_zero,
        input  br_ready, res_valid, res_taken
    );

    modport slave (
        input  br_valid, br_kind, br_cond, reg_zero,
        output br_ready, res_valid, res_taken
    );
endinterface

// File: rtl/cond_unit.sv
// cond_unit: consumer end of the ALU flag interface.
//
// Holds the architectural NZCV register, counts in-flight flag-setting
// instructions, stalls B.cond while any older flag-setter is outstanding,
// and resolves B.cond / CBZ / CBNZ / B with a registered taken decision one
// cycle after acceptance.
//
// Ports:
//   clk           clock, all state on rising edge
//   reset         synchronous active-high reset
//   flag_issue    a flag-setting instruction enters the pipeline
//   flag_we       a flag-setting instruction writes back (alu_* valid)
//   alu_negative  N, alu_zero Z, alu_carry C (1 = no borrow), alu_overflow V
//   br            branch handshake (cond_unit_if.slave)
//   nzcv          {N,Z,C,V} architectural flags
//   pend_cnt      in-flight flag-setter count
//   flag_err      sticky: issue attempted while the counter was full
module cond_unit #(
    parameter int MAX_PENDING = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flag_issue,
    input  logic                               flag_we,
    input  logic                               alu_negative,
    input  logic                               alu_zero,
    input  logic                               alu_carry,
    input  logic                               alu_overflow,
    cond_unit_if.slave                         br,
    output logic [3:0]                         nzcv,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pend_cnt,
    output logic                               flag_err
);
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING);

    localparam logic [1:0] KIND_BCOND = 2'b00;
    localparam logic [1:0] KIND_CBZ   = 2'b01;
    localparam logic [1:0] KIND_CBNZ  = 2'b10;

    logic [3:0]    alu_flags;
    logic [3:0]    flags_f;
    logic          we_dec;
    logic          issue_ok;
    logic          issue_drop;
    logic [CW-1:0] eff_pend;
    logic [CW-1:0] pend_next;
    logic          accept;
    logic          taken;

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic r;
        {n, z, cy, v} = f;
        r = 1'b0;
        case (c)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = cy;
            4'b0011: r = !cy;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = cy && !z;
            4'b1001: r = !cy || z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z && (n == v);
            4'b1101: r = z || (n != v);
            default: r = 1'b1;   // AL and NV both always taken
        endcase
        return r;
    endfunction

    always_comb begin
        alu_flags = {alu_negative, alu_zero, alu_carry, alu_overflow};

        // A writeback retires one pending setter, unless none is tracked.
        we_dec = flag_we && (pend_cnt != '0);

        // At the limit an issue only fits if a writeback frees a slot
        // in the same cycle.
        issue_ok   = flag_issue && ((pend_cnt != CNT_MAX) || flag_we);
        issue_drop = flag_issue && (pend_cnt == CNT_MAX) && !flag_we;

        // Modular arithmetic is safe: the +1 at CNT_MAX only happens
        // together with the -1.
        pend_next = (pend_cnt + CW'(issue_ok)) - CW'(we_dec);

        // Setters still outstanding after this cycle's writeback. An issue
        // in this cycle is younger than the branch and is not counted.
        eff_pend = pend_cnt - CW'(we_dec);

        br.br_ready = !((br.br_kind == KIND_BCOND) && (eff_pend != '0));
        accept      = br.br_valid && br.br_ready;

        // Forward writeback flags so a B.cond released by this writeback
        // sees the final values.
        flags_f = flag_we ? alu_flags : nzcv;

        taken = 1'b1;
        case (br.br_kind)
            KIND_BCOND: taken = cond_eval(br.br_cond, flags_f);
            KIND_CBZ:   taken = br.reg_zero;
            KIND_CBNZ:  taken = !br.reg_zero;
            default:    taken = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nzcv         <= 4'b0000;
            pend_cnt     <= '0;
            flag_err     <= 1'b0;
            br.res_valid <= 1'b0;
            br.res_taken <= 1'b0;
        end else begin
            if (flag_we) begin
                nzcv <= alu_flags;
            end
            pend_cnt <= pend_next;
            if (issue_drop) begin
                flag_err <= 1'b1;
            end
            br.res_valid <= accept;
            if (accept) begin
                br.res_taken <= taken;
            end
        end
    end
endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Consumer end of the 64-bit ALU flag interface.
- Holds the architectural NZCV register, written by flag-setting ops (ADDS/SUBS/ANDS) at ALU writeback.
- Tracks in-flight flag-setting instructions and stalls conditional branches until their flags are final.
- Resolves B.cond / CBZ / CBNZ / B with a valid/ready handshake and returns a registered taken decision.

Parameters:
MAX_PENDING, 3, maximum in-flight flag-setting instructions tracked; counter width = $clog2(MAX_PENDING+1).

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
flag_issue  input  1  a flag-setting instruction enters the pipeline this cycle
flag_we  input  1  a flag-setting instruction writes back this cycle
alu_negative  input  1  ALU negative flag (N)
alu_zero  input  1  ALU zero flag (Z)
alu_carry  input  1  ALU carry flag (C); 1 = no borrow on subtract
alu_overflow  input  1  ALU overflow flag (V)
br_valid  input  1  branch presented for resolution
br_ready  output  1  unit can accept the branch this cycle
br_kind  input  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 B (unconditional)
br_cond  input  4  ARM condition field, used for B.cond only
reg_zero  input  1  tested register == 0, used for CBZ/CBNZ
res_valid  output  1  one-cycle pulse: a resolution is available
res_taken  output  1  branch taken; meaningful only while res_valid=1
nzcv  output  4  {N,Z,C,V} architectural flags
pend_cnt  output  $clog2(MAX_PENDING+1)  in-flight flag-setter count
flag_err  output  1  sticky: issue attempted at MAX_PENDING

Behaviour:
- Reset values: nzcv=0000, pend_cnt=0, res_valid=0, res_taken=0, flag_err=0. Reset dominates every other input in the same cycle. Reset mid-handshake discards the pending resolution: no res_valid pulse follows.
- NZCV register: on flag_we, nzcv <= {alu_negative, alu_zero, alu_carry, alu_overflow}. Otherwise it holds.
- Pending counter: next = pend_cnt + (flag_issue accepted) - (flag_we && pend_cnt != 0).
  - flag_issue with pend_cnt==MAX_PENDING and no flag_we in the same cycle: the issue is dropped, flag_err <= 1, and flag_err holds until reset.
  - flag_we at pend_cnt==0: flags are still written; the counter stays at 0.
  - Simultaneous issue and we: the count is unchanged.
- Effective pending: eff = pend_cnt - (flag_we && pend_cnt != 0).
- br_ready is combinational: br_ready = !(br_kind==00 && eff != 0).
  - CBZ, CBNZ and B are never stalled.
  - A flag_issue in the same cycle as the branch is younger than the branch and does not block it.
- Forwarding: when flag_we and an accepted B.cond occur in the same cycle, the condition is evaluated on the incoming alu_* flags, not on the stored nzcv.
- Acceptance is br_valid && br_ready. The next cycle gives res_valid=1 and res_taken = the evaluation result, so latency is 1 cycle. Back-to-back branches are accepted every cycle.
- Non-accepted cycles: res_valid=0 and res_taken holds its previous value.
- The branch source keeps br_kind, br_cond and reg_zero stable while br_valid=1 and br_ready=0.
- Condition evaluation (flags F = forwarded or stored):
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 NV 1 (ARMv8 semantics)
- Per branch kind: CBZ taken = reg_zero; CBNZ taken = !reg_zero; B taken = 1. For these kinds br_cond and the flags are ignored.

Test Plan:
- After reset, apply flag_we with N=1 Z=0 C=0 V=1 (result of 0x7fff…ffff+0x7fff…ffff). Next cycle nzcv=1001. Then B.cond GE (1010) is accepted and gives res_valid=1, res_taken=1 one cycle later. LT gives res_taken=0.
- Pending stall: two flag_issue pulses give pend_cnt=2. B.cond EQ is held with br_valid=1 and gets br_ready=0 for the 2 cycles. The first flag_we leaves it still stalled. The second flag_we with Z=1 (SUBS 5-5) brings br_ready=1 in the same cycle. The branch uses the forwarded Z, and res_taken=1 the next cycle.
- Saturation: three issues reach pend_cnt=3. A fourth issue leaves pend_cnt=3 and sets flag_err=1, which holds through later flag_we cycles until reset.
- CBZ with pend_cnt=2: br_ready=1 immediately. reg_zero=1 gives res_taken=1. CBNZ with reg_zero=1 gives res_taken=0. B gives res_taken=1.
- Subtract carry convention: flags from SUBS 1-2 (nzcv=1000) make HI=0, LS=1, CC=1. Flags from SUBS 0xffff…ffff-1 (nzcv=1010) make HI=1, CS=1.
- Reset asserted in the acceptance cycle of a B.cond AL: the next cycle shows res_valid=0, nzcv=0000, pend_cnt=0.
